// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS instruction-fetch stage.
//   - fetch FSM state encoding
//   - instruction field bounds (opcode, jump target, immediate)
//   - default reset PC
//   - helper that turns a beq immediate into a 32-bit byte offset
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int JUMP_MSB = 25;
  localparam int JUMP_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word offset in the immediate: sign-extend and scale to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4_i  - current PC + 4
//   instr_i     - latched instruction under execution
//   branch_i    - conditional branch (beq) from control
//   zero_i      - ALU result-is-zero flag
//   selMuxPC2_i - jump from control
//   next_pc_o   - selected next PC (jump > taken branch > sequential)
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        selMuxPC2_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] jump_target_s;
  logic [31:0] branch_target_s;
  logic        unused_op_s;

  assign jump_target_s   = {pc_plus4_i[31:28], instr_i[JUMP_MSB:JUMP_LSB], 2'b00};
  assign branch_target_s = pc_plus4_i + branch_offset(instr_i[IMM_MSB:IMM_LSB]);
  // The opcode field is decoded by the control unit, not here.
  assign unused_op_s     = ^instr_i[OP_MSB:OP_LSB];

  // Priority select: a jump overrides a simultaneously taken branch.
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (selMuxPC2_i) begin
      next_pc_o = jump_target_s;
    end else if (branch_i && zero_i) begin
      next_pc_o = branch_target_s;
    end else begin
      next_pc_o = pc_plus4_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle MIPS core.
// Owns the PC, fetches over a req/ack handshake, and holds the instruction
// for its one-cycle execution slot.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   halt           - park in IDLE at the next fetch decision point
//   imem_req/addr  - fetch request and address (address is always the PC)
//   imem_ack/rdata - memory response; honoured only in FETCH
//   instr, op      - latched instruction and its opcode field
//   instr_valid    - one cycle per instruction (EXEC); commit strobe
//   pc_plus4       - PC + 4
//   branch, selMuxPC2, zero - PC update controls from control unit / ALU
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        selMuxPC2,
  input  logic        zero
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc_s;

  pc_next_logic u_pc_next_logic (
    .pc_plus4_i  (pc_plus4),
    .instr_i     (instr_q),
    .branch_i    (branch),
    .zero_i      (zero),
    .selMuxPC2_i (selMuxPC2),
    .next_pc_o   (next_pc_s)
  );

  // Outputs are pure decodes of registered state, so reset clears
  // imem_req in the same cycle it is asserted.
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign instr_valid = (state_q == ST_EXEC);
  assign pc_plus4    = pc_q + 32'd4;

  // State, PC and instruction latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: PC moves only in EXEC, instr latches only on an ack in FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // halt is deliberately ignored here so an issued request completes.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        pc_d = next_pc_s;
        if (halt) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
